// File: rtl/fft_stage_agu.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT over a bit-reversed buffer.
// Issues one butterfly op per accepted handshake and pads every stage with idle gap cycles.
module fft_stage_agu #(
  parameter int LOG2N     = 5,
  parameter int STAGE_GAP = 4,
  parameter int STAGE_W   = $clog2(LOG2N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [LOG2N-1:0]   addr_a,
  output logic [LOG2N-1:0]   addr_b,
  output logic [LOG2N-2:0]   tw_addr,
  output logic [STAGE_W-1:0] stage,
  output logic               last
);

  localparam int KW = LOG2N - 1;
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam logic [KW-1:0]      K_LAST   = '1;
  localparam logic [STAGE_W-1:0] S_LAST   = STAGE_W'(LOG2N - 1);
  localparam logic [GW-1:0]      GAP_INIT = GW'(STAGE_GAP);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               op_valid_q, op_valid_d;
  logic               last_q, last_d;
  logic [LOG2N-1:0]   addr_a_q, addr_a_d;
  logic [LOG2N-1:0]   addr_b_q, addr_b_d;
  logic [KW-1:0]      tw_addr_q, tw_addr_d;

  logic [LOG2N-1:0]   k_ext, half, pos, base;
  logic [STAGE_W-1:0] tw_shift;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          stage_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (op_ready) begin
          if (k_q == K_LAST) begin
            state_d = GAP;
            gap_d   = GAP_INIT;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      GAP: begin
        // Gap length counts whole cycles, so leave on the cycle the counter shows 1.
        if (gap_q <= GW'(1)) begin
          gap_d = '0;
          if (stage_q == S_LAST) begin
            state_d = DONE;
            stage_d = '0;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from the next k/stage so they appear registered with the op.
  always_comb begin
    k_ext      = {1'b0, k_d};
    half       = LOG2N'(1) << stage_d;
    pos        = k_ext & (half - 1'b1);
    base       = ((k_ext >> stage_d) << 1) << stage_d;
    tw_shift   = S_LAST - stage_d;
    op_valid_d = (state_d == RUN);
    busy_d     = (state_d == RUN) || (state_d == GAP);
    done_d     = (state_d == DONE);
    addr_a_d   = '0;
    addr_b_d   = '0;
    tw_addr_d  = '0;
    last_d     = 1'b0;
    if (state_d == RUN) begin
      addr_a_d  = base | pos;
      addr_b_d  = (base | pos) + half;
      tw_addr_d = KW'(pos << tw_shift);
      last_d    = (stage_d == S_LAST) && (k_d == K_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      stage_q    <= '0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_valid_q <= 1'b0;
      last_q     <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      stage_q    <= stage_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_valid_q <= op_valid_d;
      last_q     <= last_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_addr_q  <= tw_addr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign op_valid = op_valid_q;
  assign last     = last_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_addr  = tw_addr_q;
  assign stage    = stage_q;

endmodule

// File: doc/fft_stage_agu.md
Name: fft_stage_agu

Overview:
- Address/control generator that sequences an in-place radix-2 DIT FFT over an N = 2^LOG2N point complex buffer (bit-reversed input order).
- Sits directly upstream of the butterfly datapath. Each issued operation gives:
  - the two data-RAM addresses whose words become butterfly inputs A and B;
  - the twiddle-ROM address whose word becomes W.
- The downstream write-back path writes ApWB to addr_a and AnWB to addr_b.
- Inserts idle gap cycles between stages so write-backs drain before the next stage reads.

Parameters:
- LOG2N, 5, log2 of FFT size. Legal range 2..12.
- STAGE_GAP, 4, idle cycles after the last op of every stage, including the final one. Must be ≥1.
- STAGE_W, $clog2(LOG2N), width of the stage port.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a full FFT. Sampled only when idle.
- busy  out  1  high from the cycle after start is accepted until the done cycle, exclusive.
- done  out  1  one-cycle pulse when the transform is complete.
- op_valid  out  1  addr_a/addr_b/tw_addr/stage/last describe a butterfly op.
- op_ready  in  1  downstream accepts the op when op_valid && op_ready.
- addr_a  out  LOG2N  data address for butterfly A / ApWB.
- addr_b  out  LOG2N  data address for butterfly B / AnWB.
- tw_addr  out  LOG2N-1  twiddle ROM index j, where W = exp(-2πi·j/N) stored pre-scaled.
- stage  out  STAGE_W  current stage s, 0..LOG2N-1.
- last  out  1  high with the final op of the final stage.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transform):
  - state = IDLE;
  - busy, done, op_valid, last = 0;
  - addr_a, addr_b, tw_addr, stage = 0;
  - k counter and gap counter = 0.
  - No partial completion is signalled.
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - start=1 at a clock edge → RUN with s=0, k=0.
  - op_valid and busy go high the next cycle, giving a 1-cycle start-to-first-op latency.
- RUN (op_valid=1, all outputs registered):
  - For op k in 0..N/2-1, with half = 2^s and pos = k & (half-1):
    - addr_a = ((k >> s) << (s+1)) | pos;
    - addr_b = addr_a + half;
    - tw_addr = pos << (LOG2N-1-s).
  - On accept (op_valid && op_ready): k increments.
  - When op_ready=0: every output holds its value, no matter how long the stall lasts.
  - Accept of k = N/2-1 → GAP, gap counter = STAGE_GAP.
- GAP (op_valid=0):
  - The counter decrements every cycle, independent of op_ready.
  - When it reaches 0:
    - if s < LOG2N-1 → s+1, k=0, back to RUN;
    - otherwise → DONE.
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
  - start=1 in the DONE cycle is accepted exactly as in IDLE.
- start while busy is ignored; no queuing.
- last = 1 only when s = LOG2N-1 and k = N/2-1. It is held during a stall.
- Op count per transform = LOG2N·N/2.
- With op_ready tied high, done asserts LOG2N·(N/2 + STAGE_GAP) + 1 cycles after the start-sampling edge.

Test Plan (LOG2N=3, STAGE_GAP=4 unless stated):
- Reset, then start pulse with op_ready=1 → op sequence (addr_a, addr_b, tw_addr) is:
  - s0: (0,1,0) (2,3,0) (4,5,0) (6,7,0);
  - s1: (0,2,0) (1,3,2) (4,6,0) (5,7,2);
  - s2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - last is high only on (3,7,3).
- Same run, timing check → op_valid high in cycles 1-4, 9-12 and 17-20; low during gaps; done pulse in cycle 25; busy high cycles 1-24.
- op_ready driven low for 3 cycles while op (1,3,2) is presented → outputs frozen for those 3 cycles; sequence resumes unchanged; done is delayed by exactly 3 cycles.
- start asserted again in cycle 10 mid-run → ignored; sequence and done timing unchanged. start asserted in the done cycle → new run begins, op_valid high in the next cycle.
- rst_n pulled low asynchronously mid stage 1 → all outputs 0 immediately, with no done. The next start → full sequence from (0,1,0).
- LOG2N=5, STAGE_GAP=1, op_ready=1 → 80 ops; the final op is (15,31,15) with last=1; done 86 cycles after the start-sampling edge.
